// File: rtl/arbitro_mux4_rr_if.sv
// Bundle of the four requester words, their requests, the downstream
// handshake and the scheduler status outputs of arbitro_mux4_rr.
interface arbitro_mux4_rr_if #(
    parameter int n = 4
);
    logic [3:0]   i_req;
    logic [n-1:0] i_Datos_0;
    logic [n-1:0] i_Datos_1;
    logic [n-1:0] i_Datos_2;
    logic [n-1:0] i_Datos_3;
    logic         i_ready;
    logic [1:0]   o_sel;
    logic [3:0]   o_grant;
    logic [3:0]   o_ack;
    logic [n-1:0] o_Datos;
    logic         o_valid;
    logic         o_busy;

    // Producers and the consumer drive the request/data/ready side.
    modport master (
        output i_req, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_ready,
        input  o_sel, o_grant, o_ack, o_Datos, o_valid, o_busy
    );

    // The scheduler consumes requests and drives the mux/output stage.
    modport slave (
        input  i_req, i_Datos_0, i_Datos_1, i_Datos_2, i_Datos_3, i_ready,
        output o_sel, o_grant, o_ack, o_Datos, o_valid, o_busy
    );
endinterface

// File: rtl/arbitro_mux4_rr.sv
// Round-robin scheduler for a shared 4:1 n-bit mux. A grant FSM picks one
// requester, streams up to MAX_BURST beats from it into a registered
// valid/ready output stage, acks each captured beat, then rotates.
module arbitro_mux4_rr #(
    parameter int n         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    arbitro_mux4_rr_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_sel;
    logic [3:0]    r_grant;
    logic [CW-1:0] r_cnt;
    logic [n-1:0]  r_datos;
    logic          r_valid;
    logic          r_busy;

    logic [1:0]    w_pick;
    logic          w_found;
    logic [n-1:0]  w_mux;
    logic          w_xfer;
    logic          w_last;
    logic [3:0]    w_ack;

    // Round-robin scan of the request vector starting at the priority pointer.
    always_comb begin
        logic [1:0] v_idx;
        v_idx   = r_ptr;
        w_pick  = r_ptr;
        w_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            v_idx = r_ptr + 2'(i);
            if (!w_found && bus.i_req[v_idx]) begin
                w_pick  = v_idx;
                w_found = 1'b1;
            end
        end
    end

    // Shared selection mux driven by the registered select.
    always_comb begin
        case (r_sel)
            2'd0:    w_mux = bus.i_Datos_0;
            2'd1:    w_mux = bus.i_Datos_1;
            2'd2:    w_mux = bus.i_Datos_2;
            default: w_mux = bus.i_Datos_3;
        endcase
    end

    // A beat moves when the granted requester asks and the output slot is free or draining.
    assign w_xfer = (r_state == GRANT) && bus.i_req[r_sel] && (!r_valid || bus.i_ready);
    assign w_last = (r_cnt == CW'(MAX_BURST - 1));
    assign w_ack  = w_xfer ? (4'b0001 << r_sel) : '0;

    // Grant FSM, burst counter and registered output stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_datos <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Output slot: capture on a beat, otherwise drain when the consumer takes it.
            if (w_xfer) begin
                r_datos <= w_mux;
                r_valid <= 1'b1;
            end else if (r_valid && bus.i_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_sel   <= w_pick;
                        r_grant <= 4'b0001 << w_pick;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    // Leave after the final beat of a burst, or when the owner withdraws.
                    if ((w_xfer && w_last) || (!w_xfer && !bus.i_req[r_sel])) begin
                        r_state <= IDLE;
                        r_ptr   <= r_sel + 2'd1;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_sel   = r_sel;
    assign bus.o_grant = r_grant;
    assign bus.o_ack   = w_ack;
    assign bus.o_Datos = r_datos;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = r_busy;
endmodule

// File: tb/tb_arbitro_mux4_rr.sv
// Scoreboard bench for arbitro_mux4_rr: a transaction-level reference model
// predicts per-cycle grant/ack status and the stream of captured words.
module tb_arbitro_mux4_rr;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    arbitro_mux4_rr_if #(.n(N)) bus();

    arbitro_mux4_rr #(.n(N), .MAX_BURST(MB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0] ack;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       valid;
        logic       ready;
    } rec_t;

    int compared   = 0;
    int mismatched = 0;

    rec_t         recq[$];
    logic [N-1:0] wordq[$];

    // Reference state: who owns the mux (-1 = nobody), rotation start, last select, beats given.
    int owner = -1;
    int ptr   = 0;
    int sel   = 0;
    int beats = 0;

    // Stimulus knobs.
    int           p_raise  = 0;
    int           p_drop   = 0;
    int           p_ready  = 100;
    logic [3:0]   en_mask  = '0;
    bit           fixed_en = 1'b0;
    logic [N-1:0] fixed_v  = '0;
    logic [3:0]   acks_seen;

    function automatic logic [N-1:0] data_of(int k);
        case (k)
            0:       return bus.i_Datos_0;
            1:       return bus.i_Datos_1;
            2:       return bus.i_Datos_2;
            default: return bus.i_Datos_3;
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluate the cycle from current inputs, record expectations, advance.
    always @(negedge clk) begin
        rec_t       r;
        logic [3:0] req;
        bit         xfer;
        bit         found;
        req = bus.i_req;
        if (!rst_n) begin
            owner = -1;
            ptr   = 0;
            sel   = 0;
            beats = 0;
            wordq.delete();
        end
        r.grant = (owner < 0) ? 4'b0000 : 4'(1 << owner);
        r.sel   = 2'(sel);
        r.busy  = (owner >= 0);
        r.valid = (wordq.size() != 0);
        r.ready = bus.i_ready;
        xfer    = (owner >= 0) && req[owner] && (!r.valid || bus.i_ready);
        r.ack   = xfer ? 4'(1 << owner) : 4'b0000;
        recq.push_back(r);
        if (rst_n) begin
            if (owner < 0) begin
                found = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!found && req[(ptr + i) % 4]) begin
                        owner = (ptr + i) % 4;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    sel   = owner;
                    beats = 0;
                end
            end else if (xfer) begin
                wordq.push_back(data_of(owner));
                beats++;
                if (beats == MB) begin
                    ptr   = (owner + 1) % 4;
                    owner = -1;
                    beats = 0;
                end
            end else if (!req[owner]) begin
                ptr   = (owner + 1) % 4;
                owner = -1;
                beats = 0;
            end
        end
    end

    // Monitor: compare status every cycle and the presented word against the scoreboard.
    always @(negedge clk) begin
        rec_t r;
        #1;
        if (recq.size() == 0) begin
            check("recq_underflow", 32'd1, 32'd0);
        end else begin
            r = recq.pop_front();
            check("ack",   32'(bus.o_ack),   32'(r.ack));
            check("grant", 32'(bus.o_grant), 32'(r.grant));
            check("sel",   32'(bus.o_sel),   32'(r.sel));
            check("busy",  32'(bus.o_busy),  32'(r.busy));
            check("valid", 32'(bus.o_valid), 32'(r.valid));
            if (r.valid) begin
                if (wordq.size() == 0) begin
                    check("word_underflow", 32'd1, 32'd0);
                end else begin
                    check("data", 32'(bus.o_Datos), 32'(wordq[0]));
                    if (r.ready) void'(wordq.pop_front());
                end
            end
        end
    end

    task automatic set_data(int k);
        logic [N-1:0] v;
        v = fixed_en ? fixed_v : N'($urandom);
        case (k)
            0:       bus.i_Datos_0 = v;
            1:       bus.i_Datos_1 = v;
            2:       bus.i_Datos_2 = v;
            default: bus.i_Datos_3 = v;
        endcase
    endtask

    // One cycle of producer/consumer behaviour; data only changes while idle or right after an ack.
    task automatic step();
        @(negedge clk);
        acks_seen = bus.o_ack;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (bus.i_req[k]) begin
                if (acks_seen[k]) begin
                    set_data(k);
                    if (!en_mask[k] || ($urandom_range(99) < 32'(p_drop))) bus.i_req[k] = 1'b0;
                end
            end else if (en_mask[k] && ($urandom_range(99) < 32'(p_raise))) begin
                set_data(k);
                bus.i_req[k] = 1'b1;
            end
        end
        bus.i_ready = ($urandom_range(99) < 32'(p_ready));
    endtask

    task automatic run(int n_cycles);
        for (int c = 0; c < n_cycles; c++) step();
    endtask

    task automatic quiesce();
        en_mask  = '0;
        p_ready  = 100;
        fixed_en = 1'b0;
        run(40);
    endtask

    initial begin
        bus.i_req     = '0;
        bus.i_Datos_0 = '0;
        bus.i_Datos_1 = '0;
        bus.i_Datos_2 = '0;
        bus.i_Datos_3 = '0;
        bus.i_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Lone requester 1 with a constant word and an always-ready consumer.
        en_mask = 4'b0010; p_raise = 100; p_drop = 0; p_ready = 100;
        fixed_en = 1'b1; fixed_v = 4'hA;
        run(16);
        quiesce();

        // All four requesting continuously: full rotation with full bursts.
        en_mask = 4'b1111; p_raise = 100; p_drop = 0; p_ready = 100;
        run(44);
        quiesce();

        // Requester 2 under heavy backpressure.
        en_mask = 4'b0100; p_raise = 100; p_drop = 0; p_ready = 20;
        run(40);
        quiesce();

        // Requesters 0 and 3 with early withdrawal.
        en_mask = 4'b1001; p_raise = 100; p_drop = 40; p_ready = 100;
        run(40);
        quiesce();

        // Mixed random traffic with a reset in the middle of activity.
        en_mask = 4'b1111; p_raise = 40; p_drop = 25; p_ready = 70;
        run(200);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(300);
        quiesce();

        check("drain_empty", 32'(wordq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/arbitro_mux4_rr.md
Name: arbitro_mux4_rr

Overview:
- Round-robin scheduler that shares the 4-input n-bit selection mux among four requesters.
- Drives the mux select from a grant FSM.
- Captures the selected word into a registered output stage with a valid/ready handshake.
- Acknowledges each accepted beat back to its requester.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- n, 4, data width of each requester word and of o_Datos.
- MAX_BURST, 4, maximum beats transferred per grant before rotation (legal range 1..255).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  4  request per requester; bit k pairs with i_Datos_k.
- i_Datos_0  input  n  requester 0 data.
- i_Datos_1  input  n  requester 1 data.
- i_Datos_2  input  n  requester 2 data.
- i_Datos_3  input  n  requester 3 data.
- i_ready  input  1  downstream accepts o_Datos this cycle.
- o_sel  output  2  registered mux select (index of current/last grant).
- o_grant  output  4  one-hot grant; all zero in IDLE.
- o_ack  output  4  one-cycle pulse: beat from requester k captured this cycle.
- o_Datos  output  n  registered output word.
- o_valid  output  1  o_Datos holds an unconsumed word.
- o_busy  output  1  FSM in GRANT.

Behaviour:
- Reset (async, i_rst_n=0): IDLE, priority pointer=0, o_sel=0, o_grant=0, o_ack=0, o_Datos=0, o_valid=0, o_busy=0, burst count=0. Any word held in the output register is discarded. Reset mid-burst gives no further o_ack.
- Requester rule: i_Datos_k must stay stable while i_req[k]=1 until the matching o_ack[k] pulse. A new word may follow immediately after the ack.
- Definition: xfer = GRANT & i_req[g] & (~o_valid | i_ready), where g is the granted index.

IDLE state:
- If i_req != 0, choose the first set bit scanning pointer, pointer+1, ..., pointer+3 (mod 4).
- Next cycle: GRANT, o_sel=g, o_grant=onehot(g), o_busy=1, count=0.
- If i_req=0, stay in IDLE with outputs unchanged (o_sel holds its last value).

GRANT state:
- On xfer: o_Datos <= i_Datos_g, o_valid <= 1, o_ack[g]=1 for exactly that cycle, count <= count+1.
- When there is no xfer and o_valid & i_ready: o_valid <= 0.
- When xfer and i_ready occur in the same cycle, o_valid stays 1 and the word is replaced.
- Exit to IDLE (next cycle) when either:
  - i_req[g]=0 with no xfer, or
  - the xfer makes count reach MAX_BURST.
- On exit: pointer <= (g+1) mod 4, o_grant <= 0, o_busy <= 0, count <= 0. o_valid and o_Datos persist until consumed.

Timing and edge cases:
- Latency: request seen in IDLE at cycle t gives grant at t+1. First capture is at the end of t+1, so o_valid=1 at t+2.
- Each re-grant costs one IDLE bubble cycle.
- Sustained throughput within a burst: 1 beat/cycle while i_ready=1.
- Backpressure: with o_valid=1 and i_ready=0 there is no xfer and no ack. The grant holds indefinitely and does not count toward MAX_BURST.
- Requests in other bits during GRANT are ignored until IDLE. Simultaneous requests resolve only by the pointer.
- A requester dropping i_req mid-burst forfeits the rest of its burst; the pointer still advances past it.
- Count width is ceil(log2(MAX_BURST+1)); no wrap is possible.

Test Plan:
- Reset: assert i_rst_n=0 mid-burst with o_valid=1 -> next sample shows all outputs 0, pointer=0. After release with i_req=4'b1000, grant goes to 3 at +1 and the first o_Datos arrives at +2.
- Single requester: i_req=4'b0010, i_Datos_1=4'hA, i_ready=1 held. Required:
  - o_ack[1] pulses on 4 consecutive cycles.
  - o_Datos=4'hA with o_valid continuous.
  - Return to IDLE, one bubble, then re-grant to 1.
- Fairness: i_req=4'b1111 constant, MAX_BURST=4, i_ready=1 -> grant order 0,1,2,3,0, each with exactly 4 acks. o_sel follows 0,1,2,3.
- Backpressure: grant 2 active, i_ready=0 for 5 cycles after the first capture. Required:
  - o_valid=1 and o_Datos stable throughout.
  - No o_ack pulses.
  - After i_ready=1, beats resume at 1/cycle.
- Early release: grant 0, i_req[0] drops after 2 acks while i_req[3]=1 -> IDLE for one cycle, then grant 3 (pointer=1 scan skips idle 1,2).
- Wrap: pointer=3, i_req=4'b0101 -> grant 0; after its burst, pointer=1 and grant goes to 2.
